// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI ADC master: the FSM state encoding and the
// default frame geometry (sclk half-period in clk cycles, bits per frame).
// No ports; imported by spi_sclk_gen and spi_adc_master.
// -----------------------------------------------------------------------------
package spi_pkg;

    // Default clk cycles per sclk half-period.
    localparam int DEF_DIV_HALF = 4;

    // Default bits per frame.
    localparam int DEF_WIDTH    = 16;

    // Transfer phases. The encoding is exported on the debug state port,
    // so keep it stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // cs high, waiting for start
        SETUP = 2'd1,   // cs low, sclk low, first bit on mosi
        XFER  = 2'd2,   // sclk toggling, shifting data
        HOLD  = 2'd3    // cs still low, sclk low, before release
    } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Half-period timer and SPI clock generator. A counter runs 0..DIV_HALF-1 and
// wraps; the wrap cycle is the half-period tick. While i_toggle is high each
// tick flips sclk, and the rise/fall strobes mark the clk cycle whose edge
// produces the sclk transition.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   i_clr    in   synchronous clear of the half-period counter (overrides wrap)
//   i_toggle in   allow sclk to toggle on ticks; sclk is held low otherwise
//   o_tick   out  half-period tick (counter at DIV_HALF-1, not being cleared)
//   o_rise   out  this cycle's edge drives sclk 0 -> 1
//   o_fall   out  this cycle's edge drives sclk 1 -> 0
//   o_sclk   out  registered SPI clock, idle low
// -----------------------------------------------------------------------------
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_toggle,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    // DIV_HALF >= 2, so CW is at least 1.
    localparam int            CW   = $clog2(DIV_HALF);
    localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          w_tick;

    assign w_tick = (r_cnt == LAST) && !i_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk <= 1'b0;
        end else if (!i_toggle) begin
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign o_tick = w_tick;
    assign o_rise = w_tick && i_toggle && !r_sclk;
    assign o_fall = w_tick && i_toggle &&  r_sclk;
    assign o_sclk = r_sclk;

endmodule

// File: rtl/spi_adc_master.sv
// -----------------------------------------------------------------------------
// spi_adc_master
// SPI mode-0 master for a single-frame ADC style transaction: one WIDTH-bit
// word out on mosi (MSB first) while one WIDTH-bit word is sampled from miso.
//
// Request/response protocol: start is a request that is only looked at in
// IDLE; the clk edge that sees start=1 in IDLE is the accept edge and also
// captures tx_data. busy is high from the cycle after accept up to, but not
// including, the cycle in which done pulses. done is a one-cycle pulse and
// rx_data is updated in that same cycle and held until the next done. start
// may be held high; the next frame is accepted in the cycle after done.
//
// Frame timing (D = DIV_HALF, W = WIDTH), counted in edges after accept:
//   SETUP D cycles, XFER 2*W half-periods plus one settle cycle in which the
//   bit counter reports W falls, HOLD D cycles -> done at D*(2W+2)+1.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset, aborts any frame
//   start     in   transfer request, sampled in IDLE only
//   tx_data   in   [WIDTH-1:0] frame to send, captured at accept
//   rx_data   out  [WIDTH-1:0] last received frame
//   busy      out  frame in progress
//   done      out  one-cycle completion pulse
//   sclk      out  SPI clock, idle low
//   cs        out  chip select, active low
//   mosi      out  serial data out
//   miso      in   serial data in, already synchronous to clk
//   dbg_state out  [1:0] current FSM state (spi_state_t encoding)
// -----------------------------------------------------------------------------
module spi_adc_master
    import spi_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso,
    output logic [1:0]       dbg_state
);

    // One extra bit so the count of falls can reach WIDTH without wrapping.
    localparam int BW = $clog2(WIDTH) + 1;

    spi_state_t       r_state;
    spi_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_rx_data;
    logic [BW-1:0]    r_bit_cnt;   // sclk falling edges seen this frame
    logic             r_cs;
    logic             r_mosi;
    logic             r_done;

    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_sclk;
    logic             w_accept;
    logic             w_enter_hold;
    logic             w_leave_hold;
    logic             w_clr;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_enter_hold = (r_state == XFER) && (r_bit_cnt == BW'(WIDTH));
    assign w_leave_hold = (r_state == HOLD) && w_tick;

    // The counter sits at zero in IDLE so SETUP starts a full half-period,
    // and restarts on entry to HOLD so HOLD lasts a full half-period too.
    assign w_clr = (r_state == IDLE) || w_enter_hold;

    spi_sclk_gen #(
        .DIV_HALF (DIV_HALF)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_toggle (r_state == XFER),
        .o_tick   (w_tick),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
        .o_sclk   (w_sclk)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)        w_state_nxt = SETUP;
            SETUP:   if (w_tick)       w_state_nxt = XFER;
            XFER:    if (w_enter_hold) w_state_nxt = HOLD;
            HOLD:    if (w_tick)       w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_tx      <= tx_data;
                r_mosi    <= tx_data[WIDTH-1];
                r_cs      <= 1'b0;
                r_bit_cnt <= '0;
                r_rx      <= '0;
            end

            // Sample miso on the cycle whose edge raises sclk, i.e. the
            // slave has held the bit stable for the whole low half-period.
            if (w_rise) begin
                r_rx <= {r_rx[WIDTH-2:0], miso};
            end

            // Advance mosi on every fall except the last, so the final bit
            // stays put through HOLD until cs is released.
            if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
                if (r_bit_cnt != BW'(WIDTH - 1)) begin
                    r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
                    r_mosi <= r_tx[WIDTH-2];
                end
            end

            if (w_leave_hold) begin
                r_cs      <= 1'b1;
                r_mosi    <= 1'b0;
                r_rx_data <= r_rx;
                r_done    <= 1'b1;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign sclk      = w_sclk;
    assign cs        = r_cs;
    assign mosi      = r_mosi;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_adc_master.sv
// -----------------------------------------------------------------------------
// tb_spi_adc_master
// Self-checking bench for spi_adc_master. Two instances: the default
// geometry (WIDTH=16, DIV_HALF=4) and a small one (WIDTH=8, DIV_HALF=2).
// Expected receive words go into exp_q when a frame is launched and are
// popped when done is seen.
// -----------------------------------------------------------------------------
module tb_spi_adc_master;
    import spi_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        start;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        busy, done, sclk, cs, mosi, miso;
    logic [1:0]  dbg_state;

    logic        start_s;
    logic [7:0]  tx_data_s;
    logic [7:0]  rx_data_s;
    logic        busy_s, done_s, sclk_s, cs_s, mosi_s, miso_s;
    logic [1:0]  dbg_state_s;

    spi_adc_master #(.DIV_HALF(4), .WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
        .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk),
        .cs(cs), .mosi(mosi), .miso(miso), .dbg_state(dbg_state)
    );

    spi_adc_master #(.DIV_HALF(2), .WIDTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .tx_data(tx_data_s),
        .rx_data(rx_data_s), .busy(busy_s), .done(done_s), .sclk(sclk_s),
        .cs(cs_s), .mosi(mosi_s), .miso(miso_s), .dbg_state(dbg_state_s)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Driver: launch one frame on the main instance and follow it.
    // Cycle 0 is the accept edge. The slave either loops mosi back or
    // shifts out slave_word MSB first, changing on sclk falls.
    // ------------------------------------------------------------------
    task automatic run_frame(input  logic [15:0] tx,
                             input  bit          loopback,
                             input  logic [15:0] slave_word,
                             input  int          pulse_a,
                             input  int          pulse_b,
                             output int          done_cyc,
                             output int          rises,
                             output int          ctrl_bad,
                             output logic [15:0] mosi_bits,
                             output logic [15:0] rx_got);
        logic [15:0] sh;
        logic        prev;
        done_cyc  = -1;
        rises     = 0;
        ctrl_bad  = 0;
        mosi_bits = '0;
        rx_got    = 'x;
        sh        = slave_word;
        @(posedge clk); #1;
        start   = 1'b1;
        tx_data = tx;
        @(posedge clk); #1;
        start   = 1'b0;
        tx_data = 16'($urandom);       // must not disturb the frame in flight
        miso    = loopback ? mosi : sh[15];
        prev    = sclk;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == pulse_a) || (cyc == pulse_b);
            if (sclk && !prev) begin
                rises++;
                mosi_bits = {mosi_bits[14:0], mosi};
            end
            if (!sclk && prev) sh = {sh[14:0], 1'b0};
            miso = loopback ? mosi : sh[15];
            prev = sclk;
            if (busy !== (cyc < 137) || cs !== (cyc >= 137)) ctrl_bad++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                rx_got   = rx_data;
                break;
            end
        end
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cs !== 1'b1)        begin n_err++; $display("FAIL reset_cs: got %b expected 1", cs); end
        n_cmp++; if (sclk !== 1'b0)      begin n_err++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        n_cmp++; if (mosi !== 1'b0)      begin n_err++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (rx_data !== 16'h0)  begin n_err++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        n_cmp++; if (cs_s !== 1'b1)      begin n_err++; $display("FAIL reset_cs_small: got %b expected 1", cs_s); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || cs !== 1'b1) begin
            n_err++; $display("FAIL idle_after_reset: busy=%b cs=%b expected busy=0 cs=1", busy, cs);
        end
    endtask

    task automatic test_loopback();
        int dc, rs, cb;
        logic [15:0] mb, rx, exp;
        exp_q.push_back(16'hA5C3);
        run_frame(16'hA5C3, 1'b1, 16'h0, -1, -1, dc, rs, cb, mb, rx);
        n_cmp++; if (dc !== 137)      begin n_err++; $display("FAIL loopback_done_cycle: got %0d expected 137", dc); end
        n_cmp++; if (rs !== 16)       begin n_err++; $display("FAIL loopback_sclk_rises: got %0d expected 16", rs); end
        n_cmp++; if (cb !== 0)        begin n_err++; $display("FAIL loopback_busy_cs: got %0d bad cycles expected 0", cb); end
        n_cmp++; if (mb !== 16'hA5C3) begin n_err++; $display("FAIL loopback_mosi_bits: got %h expected a5c3", mb); end
        if (dc >= 0) begin
            exp = exp_q.pop_front();
            n_cmp++; if (rx !== exp) begin n_err++; $display("FAIL loopback_rx: got %h expected %h", rx, exp); end
        end else begin
            exp_q.delete();
        end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        n_cmp++; if (rx_data !== 16'hA5C3) begin n_err++; $display("FAIL rx_held: got %h expected a5c3", rx_data); end
    endtask

    task automatic test_slave();
        int dc, rs, cb;
        logic [15:0] mb, rx, exp, tx, sw;
        for (int i = 0; i < 3; i++) begin
            tx = (i == 0) ? 16'hC35A : 16'($urandom_range(0, 65535));
            sw = (i == 0) ? 16'h03FF : 16'($urandom_range(0, 65535));
            exp_q.push_back(sw);
            run_frame(tx, 1'b0, sw, -1, -1, dc, rs, cb, mb, rx);
            n_cmp++; if (dc !== 137) begin n_err++; $display("FAIL slave_done_cycle[%0d]: got %0d expected 137", i, dc); end
            n_cmp++; if (mb !== tx)  begin n_err++; $display("FAIL slave_mosi_bits[%0d]: got %h expected %h", i, mb, tx); end
            if (dc >= 0) begin
                exp = exp_q.pop_front();
                n_cmp++; if (rx !== exp) begin n_err++; $display("FAIL slave_rx[%0d]: got %h expected %h", i, rx, exp); end
            end else begin
                exp_q.delete();
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc, rs, cb, extra_done, extra_cs;
        logic [15:0] mb, rx, exp;
        exp_q.push_back(16'h5A3C);
        run_frame(16'h5A3C, 1'b1, 16'h0, 10, 50, dc, rs, cb, mb, rx);
        n_cmp++; if (dc !== 137) begin n_err++; $display("FAIL ignore_done_cycle: got %0d expected 137", dc); end
        n_cmp++; if (cb !== 0)   begin n_err++; $display("FAIL ignore_busy_cs: got %0d bad cycles expected 0", cb); end
        if (dc >= 0) begin
            exp = exp_q.pop_front();
            n_cmp++; if (rx !== exp) begin n_err++; $display("FAIL ignore_rx: got %h expected %h", rx, exp); end
        end else begin
            exp_q.delete();
        end
        extra_done = 0;
        extra_cs   = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra_done++;
            if (cs !== 1'b1)   extra_cs++;
        end
        n_cmp++; if (extra_done !== 0) begin n_err++; $display("FAIL ignore_extra_done: got %0d pulses expected 0", extra_done); end
        n_cmp++; if (extra_cs !== 0)   begin n_err++; $display("FAIL ignore_extra_frame: got %0d cs-low cycles expected 0", extra_cs); end
    endtask

    task automatic test_reset_abort();
        int n_done, cs_low;
        @(posedge clk); #1;
        start   = 1'b1;
        tx_data = 16'hF00F;
        miso    = 1'b1;
        @(posedge clk); #1;           // accept edge = cycle 0
        start = 1'b0;
        repeat (60) @(posedge clk);
        #3;
        n_cmp++; if (cs !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL abort_mid_frame: cs=%b busy=%b expected cs=0 busy=1", cs, busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cs !== 1'b1)       begin n_err++; $display("FAIL abort_cs: got %b expected 1", cs); end
        n_cmp++; if (sclk !== 1'b0)     begin n_err++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (mosi !== 1'b0)     begin n_err++; $display("FAIL abort_mosi: got %b expected 0", mosi); end
        n_cmp++; if (rx_data !== 16'h0) begin n_err++; $display("FAIL abort_rx_data: got %h expected 0000", rx_data); end
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        miso   = 1'b0;
        n_done = 0;
        cs_low = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
            if (cs !== 1'b1)   cs_low++;
        end
        n_cmp++; if (n_done !== 0)      begin n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
        n_cmp++; if (cs_low !== 0)      begin n_err++; $display("FAIL abort_no_resume: got %0d cs-low cycles expected 0", cs_low); end
        n_cmp++; if (rx_data !== 16'h0) begin n_err++; $display("FAIL abort_rx_after: got %h expected 0000", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] t[3];
        logic [15:0] exp;
        int n_done, last, gap;
        bit in_gap;
        for (int i = 0; i < 3; i++) begin
            t[i] = 16'($urandom_range(1, 65535));
            exp_q.push_back(t[i]);
        end
        @(posedge clk); #1;
        start   = 1'b1;
        tx_data = t[0];
        @(posedge clk); #1;           // first accept edge = cycle 0
        tx_data = 16'($urandom);
        miso    = mosi;
        n_done  = 0;
        last    = 0;
        gap     = 0;
        in_gap  = 1'b0;
        for (int cyc = 1; cyc <= 600 && n_done < 3; cyc++) begin
            @(posedge clk); #1;
            miso = mosi;
            if (done === 1'b1) begin
                n_done++;
                exp = exp_q.pop_front();
                n_cmp++; if (rx_data !== exp) begin n_err++; $display("FAIL b2b_rx[%0d]: got %h expected %h", n_done, rx_data, exp); end
                n_cmp++; if ((cyc - last) !== ((n_done == 1) ? 137 : 138)) begin
                    n_err++; $display("FAIL b2b_done_spacing[%0d]: got %0d expected %0d", n_done, cyc - last, (n_done == 1) ? 137 : 138);
                end
                last   = cyc;
                gap    = 0;
                in_gap = 1'b1;
                if (n_done < 3) tx_data = t[n_done];
                else            start   = 1'b0;
            end
            if (in_gap) begin
                if (cs === 1'b1) begin
                    gap++;
                end else begin
                    n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d cycles expected 1", gap); end
                    in_gap  = 1'b0;
                    tx_data = 16'($urandom);
                end
            end
        end
        start = 1'b0;
        n_cmp++; if (n_done !== 3) begin
            n_err++; $display("FAIL b2b_frames: got %0d done pulses expected 3", n_done);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || cs !== 1'b1) begin
            n_err++; $display("FAIL b2b_idle_after: busy=%b cs=%b expected busy=0 cs=1", busy, cs);
        end
    endtask

    task automatic test_small();
        int dc, rises, last_rise, period_bad;
        logic prev;
        logic [15:0] exp;
        exp_q.push_back(16'h0081);
        @(posedge clk); #1;
        start_s   = 1'b1;
        tx_data_s = 8'h81;
        @(posedge clk); #1;           // accept edge = cycle 0
        start_s    = 1'b0;
        tx_data_s  = 8'($urandom);
        miso_s     = mosi_s;
        prev       = sclk_s;
        dc         = -1;
        rises      = 0;
        last_rise  = -1;
        period_bad = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            miso_s = mosi_s;
            if (sclk_s && !prev) begin
                rises++;
                if (last_rise >= 0 && (cyc - last_rise) != 4) period_bad++;
                last_rise = cyc;
            end
            prev = sclk_s;
            if (done_s === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        n_cmp++; if (dc !== 37)        begin n_err++; $display("FAIL small_done_cycle: got %0d expected 37", dc); end
        n_cmp++; if (rises !== 8)      begin n_err++; $display("FAIL small_sclk_rises: got %0d expected 8", rises); end
        n_cmp++; if (period_bad !== 0) begin n_err++; $display("FAIL small_sclk_period: got %0d bad periods expected 0", period_bad); end
        if (dc >= 0) begin
            exp = exp_q.pop_front();
            n_cmp++; if ({8'h00, rx_data_s} !== exp) begin n_err++; $display("FAIL small_rx: got %h expected %h", rx_data_s, exp[7:0]); end
        end else begin
            exp_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        start     = 1'b0;
        tx_data   = '0;
        miso      = 1'b0;
        start_s   = 1'b0;
        tx_data_s = '0;
        miso_s    = 1'b0;

        test_reset();
        test_loopback();
        test_slave();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_small();

        n_cmp++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drained: got %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_adc_master.md
SPI_ADC_MASTER -- requirements
Module: spi_adc_master

Interface
REQ-001 SHALL have parameter DIV_HALF, default 4: clk cycles per sclk half-period; legal range 2..255.
REQ-002 SHALL have parameter WIDTH, default 16: bits per frame; legal range 8..32.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  transfer request, sampled in IDLE only.
REQ-006 SHALL have port tx_data  input  WIDTH  frame to transmit, MSB first, captured at start accept.
REQ-007 SHALL have port rx_data  output  WIDTH  last received frame, held until the next done.
REQ-008 SHALL have port busy  output  1  high from the cycle after start accept until the done cycle, exclusive of the done cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.
REQ-010 SHALL have port sclk  output  1  SPI clock to the downstream device, mode 0 (idle low).
REQ-011 SHALL have port cs  output  1  chip select, active-low.
REQ-012 SHALL have port mosi  output  1  serial data out.
REQ-013 SHALL have port miso  input  1  serial data in, assumed already synchronous to clk.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, XFER, HOLD.
REQ-015 SHALL, in IDLE with start=1, capture tx_data, drive cs=0 and mosi=tx_data[WIDTH-1], and go to SETUP.
REQ-016 SHALL stay in SETUP for DIV_HALF cycles with sclk=0, then go to XFER.
REQ-017 SHALL, in XFER, toggle sclk every DIV_HALF cycles, giving exactly WIDTH rising edges and WIDTH falling edges.
REQ-018 SHALL shift miso into the receive register, MSB first, on the clk cycle that produces each sclk rising edge.
REQ-019 SHALL update mosi to the next lower bit on each sclk falling edge except the last one.
REQ-020 SHALL go to HOLD after the WIDTH-th falling edge and keep cs=0, sclk=0 for DIV_HALF cycles.
REQ-021 SHALL, on leaving HOLD, drive cs=1 and mosi=0, load rx_data, pulse done for one cycle, and return to IDLE.
REQ-022 SHALL assert done exactly DIV_HALF*(2*WIDTH+2)+1 clk cycles after the start-accept edge.
REQ-023 SHALL ignore start whenever the FSM is not in IDLE; tx_data changes during a transfer SHALL have no effect.
REQ-024 SHALL accept start in the cycle after done, giving a minimum cs-high gap of 1 clk cycle between frames.
REQ-025 SHALL use a half-period counter that wraps to 0 at DIV_HALF-1 and a bit counter of width clog2(WIDTH)+1 that never wraps within a frame.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, and clear all counters.
REQ-027 SHALL, on reset during a transfer, abort the transfer immediately with no done pulse, and leave rx_data=0.

Structure
REQ-028 SHALL take the FSM state encoding and the default DIV_HALF and WIDTH values from shared package spi_pkg.
REQ-029 SHALL instantiate one sub-module, spi_sclk_gen, that produces the half-period tick and the rise/fall strobes.

Verification
REQ-030 WIDTH=16, DIV_HALF=4, tx=0xA5C3, miso looped to mosi -> rx_data=0xA5C3, done at cycle 137, 16 sclk rising edges.
REQ-031 Slave model returning 0x03FF on miso -> rx_data=0x03FF; mosi observed on sclk rising edges equals tx_data bits MSB first.
REQ-032 Pulse start at cycles 10 and 50 while busy -> exactly one frame and one done pulse.
REQ-033 rst_n low at cycle 60 of a transfer -> same-cycle cs=1, sclk=0, busy=0; no done; rx_data=0.
REQ-034 Hold start high continuously -> back-to-back frames, cs high for exactly 1 cycle between frames, done every 138 cycles.
REQ-035 DIV_HALF=2, WIDTH=8, tx=0x81 -> sclk period 4 clk cycles, done at cycle 37.
